// File: rtl/logic_sweep_pkg.sv
// logic_sweep_pkg: shared state encoding and error-counter width for the operand sweeper.
package logic_sweep_pkg;
    localparam int ERR_CNT_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/logic_operand_sweeper_if.sv
// logic_operand_sweeper_if: operand sweep bus; result-return and error-count signals
// exist only when LOGIC_SWEEP_CHECK_EN is defined.
interface logic_operand_sweeper_if #(parameter int WIDTH = 2);
    import logic_sweep_pkg::*;
    logic start;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic vld_o;
    logic busy_o;
    logic done_o;
    logic [2*WIDTH-1:0] vec_idx_o;
`ifdef LOGIC_SWEEP_CHECK_EN
    logic [WIDTH-1:0] bitwise_i;
    logic logical_i;
    logic [ERR_CNT_W-1:0] err_cnt_o;
`endif
    modport master (
        input start,
        output a_o, b_o, vld_o, busy_o, done_o, vec_idx_o
`ifdef LOGIC_SWEEP_CHECK_EN
        , input bitwise_i, logical_i
        , output err_cnt_o
`endif
    );
    modport slave (
        output start,
        input a_o, b_o, vld_o, busy_o, done_o, vec_idx_o
`ifdef LOGIC_SWEEP_CHECK_EN
        , output bitwise_i, logical_i
        , input err_cnt_o
`endif
    );
endinterface

// File: rtl/logic_sweep_ref.sv
// logic_sweep_ref: expected bitwise and logical AND of the current operand pair.
module logic_sweep_ref #(parameter int WIDTH = 2) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] bitwise,
    output logic             logical
);
    assign bitwise = a & b;
    assign logical = (|a) && (|b);
endmodule

// File: rtl/logic_operand_sweeper.sv
// logic_operand_sweeper: walks every (a,b) operand pair, holding each for HOLD cycles.
// Optional result checker enabled by macro LOGIC_SWEEP_CHECK_EN.
module logic_operand_sweeper import logic_sweep_pkg::*; #(
    parameter int WIDTH = 2,
    parameter int HOLD  = 2
) (
    input logic clk,
    input logic rst,
    logic_operand_sweeper_if.master bus
);
    localparam int IW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_IDX = '1;
    localparam logic [7:0] LAST_H = 8'(HOLD - 1);
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0] hcnt, hcnt_n;
    logic hold_end, run;
    assign hold_end = hcnt == LAST_H;
    assign run = state == RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            hcnt  <= hcnt_n;
        end
    end
    // idx parks on the last vector when RUN ends; DONE clears it for the next sweep
    always_comb begin
        state_n = state;
        idx_n   = idx;
        hcnt_n  = hcnt;
        case (state)
            IDLE: if (bus.start) begin
                state_n = RUN;
                idx_n   = '0;
                hcnt_n  = '0;
            end
            RUN: if (hold_end) begin
                hcnt_n  = '0;
                state_n = idx == LAST_IDX ? DONE : RUN;
                idx_n   = idx == LAST_IDX ? idx : idx + IW'(1);
            end else begin
                hcnt_n = hcnt + 8'd1;
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
                hcnt_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.vld_o     = run;
    assign bus.busy_o    = run;
    assign bus.done_o    = state == DONE;
    assign bus.vec_idx_o = run ? idx : '0;
    assign bus.a_o       = run ? idx[IW-1:WIDTH] : '0;
    assign bus.b_o       = run ? idx[WIDTH-1:0] : '0;
`ifdef LOGIC_SWEEP_CHECK_EN
    logic [WIDTH-1:0] exp_bw;
    logic exp_lg, bad;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic_sweep_ref #(.WIDTH(WIDTH)) u_ref (
        .a       (bus.a_o),
        .b       (bus.b_o),
        .bitwise (exp_bw),
        .logical (exp_lg)
    );
    assign bad = run && hold_end && (bus.bitwise_i != exp_bw || bus.logical_i != exp_lg);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (state == IDLE && bus.start)
            err_cnt <= '0;
        else if (bad && err_cnt != '1)
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
    assign bus.err_cnt_o = err_cnt;
`endif
endmodule

// File: tb/tb_logic_operand_sweeper.sv
// tb_logic_operand_sweeper: randomized sweeps on HOLD=2 and HOLD=1 instances against a
// cycle-count model of the sweep; fault checks run when LOGIC_SWEEP_CHECK_EN is defined.
module tb_logic_operand_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    bit sel1 = 1'b0;
    always #5 clk = ~clk;
    logic_operand_sweeper_if #(.WIDTH(2)) s2 ();
    logic_operand_sweeper_if #(.WIDTH(2)) s1 ();
    logic_operand_sweeper #(.WIDTH(2), .HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(s2));
    logic_operand_sweeper #(.WIDTH(2), .HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(s1));
    logic       c_vld, c_busy, c_done;
    logic [1:0] c_a, c_b;
    logic [3:0] c_idx;
    assign c_vld  = sel1 ? s1.vld_o : s2.vld_o;
    assign c_busy = sel1 ? s1.busy_o : s2.busy_o;
    assign c_done = sel1 ? s1.done_o : s2.done_o;
    assign c_a    = sel1 ? s1.a_o : s2.a_o;
    assign c_b    = sel1 ? s1.b_o : s2.b_o;
    assign c_idx  = sel1 ? s1.vec_idx_o : s2.vec_idx_o;
`ifdef LOGIC_SWEEP_CHECK_EN
    logic [1:0] fmask [16];
    bit flog = 1'b0;
    logic [7:0] c_err;
    assign c_err = sel1 ? s1.err_cnt_o : s2.err_cnt_o;
    always_comb begin
        s2.bitwise_i = (s2.a_o & s2.b_o) ^ fmask[s2.vec_idx_o];
        s2.logical_i = flog ? |(s2.a_o & s2.b_o) : (|s2.a_o && |s2.b_o);
        s1.bitwise_i = (s1.a_o & s1.b_o) ^ fmask[s1.vec_idx_o];
        s1.logical_i = flog ? |(s1.a_o & s1.b_o) : (|s1.a_o && |s1.b_o);
    end
    function automatic int exp_errs();
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            int a = i / 4;
            int b = i % 4;
            bit lg_bad = flog && ((a != 0 && b != 0) != ((a & b) != 0));
            if (fmask[i] != 0 || lg_bad) n++;
        end
        return n;
    endfunction
    task automatic set_faults(input bit rnd, input bit lg);
        flog = lg;
        for (int i = 0; i < 16; i++)
            fmask[i] = (rnd && $urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
    endtask
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic drive_start(input logic v);
        if (sel1) s1.start = v;
        else s2.start = v;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_vld"}, 32'(c_vld), 0);
        chk({tag, "_busy"}, 32'(c_busy), 0);
        chk({tag, "_done"}, 32'(c_done), 0);
        chk({tag, "_idx"}, 32'(c_idx), 0);
        chk({tag, "_ab"}, 32'({c_a, c_b}), 0);
    endtask
    task automatic sweep(input bit keep, input int abort_at);
        int h = sel1 ? 1 : 2;
        int n = 16 * h;
`ifdef LOGIC_SWEEP_CHECK_EN
        int e = exp_errs();
`endif
        repeat ($urandom_range(0, 3)) begin
            chk_idle("gap");
            @(negedge clk);
        end
        drive_start(1'b1);
        @(negedge clk);
        if (!keep) drive_start(1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk_idle("async_rst");
`ifdef LOGIC_SWEEP_CHECK_EN
                chk("async_rst_err", 32'(c_err), 0);
`endif
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            chk("run_vld", 32'(c_vld), 1);
            chk("run_busy", 32'(c_busy), 1);
            chk("run_done", 32'(c_done), 0);
            chk("run_idx", 32'(c_idx), k / h);
            chk("run_a", 32'(c_a), (k / h) / 4);
            chk("run_b", 32'(c_b), (k / h) % 4);
            @(negedge clk);
        end
        chk("end_done", 32'(c_done), 1);
        chk("end_vld", 32'(c_vld), 0);
        chk("end_busy", 32'(c_busy), 0);
        chk("end_idx", 32'(c_idx), 0);
`ifdef LOGIC_SWEEP_CHECK_EN
        chk("end_err", 32'(c_err), e);
`endif
        @(negedge clk);
        chk_idle("post");
`ifdef LOGIC_SWEEP_CHECK_EN
        chk("post_err_hold", 32'(c_err), e);
`endif
        if (keep) begin
            @(negedge clk);
            chk("restart_busy", 32'(c_busy), 1);
            chk("restart_idx", 32'(c_idx), 0);
`ifdef LOGIC_SWEEP_CHECK_EN
            chk("restart_err_clr", 32'(c_err), 0);
`endif
            drive_start(1'b0);
            rst = 1'b1;
            #1;
            chk_idle("restart_rst");
            @(negedge clk);
            rst = 1'b0;
        end
    endtask
    initial begin
        s1.start = 1'b0;
        s2.start = 1'b0;
`ifdef LOGIC_SWEEP_CHECK_EN
        set_faults(1'b0, 1'b0);
`endif
        repeat (2) @(negedge clk);
        chk_idle("reset2");
        sel1 = 1'b1;
        #1;
        chk_idle("reset1");
        sel1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        sweep(1'b0, -1);
`ifdef LOGIC_SWEEP_CHECK_EN
        set_faults(1'b0, 1'b1);
        sweep(1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            set_faults(1'b1, 1'($urandom));
            sweep(1'b0, -1);
        end
        set_faults(1'b1, 1'b1);
`endif
        sweep(1'b1, -1);
        sweep(1'b0, 10);
        sweep(1'b0, $urandom_range(0, 31));
        sweep(1'b0, -1);
        sel1 = 1'b1;
        @(negedge clk);
`ifdef LOGIC_SWEEP_CHECK_EN
        set_faults(1'b1, 1'b0);
`endif
        sweep(1'b0, -1);
        sweep(1'b1, -1);
        sweep(1'b0, 5);
        sweep(1'b0, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
